// File: rtl/uart_pkg.sv
// Shared definitions for the codeword UART: receiver FSM states and defaults
// common to the matching transmitter.
package uart_pkg;

    localparam int CODEWORD_W           = 7;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, with a selectable
// reset value so an idle-high line does not look active coming out of reset.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx_codeword.sv
// UART receiver delivering 7-bit Hamming codewords (start, 7 data LSB-first,
// stop) to a downstream decoder, sampling each bit at its midpoint.
module uart_rx_codeword
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = CODEWORD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    logic                 rx_s;
    rx_state_e            state_r, state_next;
    logic [CNT_W-1:0]     clk_cnt_r, clk_cnt_next;
    logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_r, shift_next;
    logic [DATA_BITS-1:0] data_r, data_next;
    logic                 valid_r, valid_next;
    logic                 ferr_r, ferr_next;
    logic                 busy_r, busy_next;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Next-state, counter, shift and output-pulse decode.
    always_comb begin
        state_next   = state_r;
        clk_cnt_next = clk_cnt_r;
        bit_cnt_next = bit_cnt_r;
        shift_next   = shift_r;
        data_next    = data_r;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (ena && !rx_s) begin
                    state_next   = ST_START;
                    clk_cnt_next = CNT_ZERO;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_START: begin
                if (clk_cnt_r == HALF_CNT) begin
                    clk_cnt_next = CNT_ZERO;
                    if (!rx_s) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = BIT_ZERO;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (clk_cnt_r == LAST_CNT) begin
                    clk_cnt_next          = CNT_ZERO;
                    shift_next[bit_cnt_r] = rx_s;
                    bit_cnt_next          = bit_cnt_r + BIT_ONE;
                    if (bit_cnt_r == LAST_BIT) begin
                        state_next = ST_STOP;
                    end else begin
                        state_next = ST_DATA;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                // Leaving at the stop-bit midpoint lets a back-to-back start bit be seen from IDLE.
                if (clk_cnt_r == LAST_CNT) begin
                    clk_cnt_next = CNT_ZERO;
                    if (rx_s) begin
                        data_next  = shift_r;
                        valid_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = ST_WAIT_IDLE;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_r + CNT_ONE;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                clk_cnt_next = CNT_ZERO;
                bit_cnt_next = BIT_ZERO;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            clk_cnt_r <= CNT_ZERO;
            bit_cnt_r <= BIT_ZERO;
            shift_r   <= {DATA_BITS{1'b0}};
            data_r    <= {DATA_BITS{1'b0}};
            valid_r   <= 1'b0;
            ferr_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next;
            clk_cnt_r <= clk_cnt_next;
            bit_cnt_r <= bit_cnt_next;
            shift_r   <= shift_next;
            data_r    <= data_next;
            valid_r   <= valid_next;
            ferr_r    <= ferr_next;
            busy_r    <= busy_next;
        end
    end

    assign data_out  = data_r;
    assign valid_out = valid_r;
    assign frame_err = ferr_r;
    assign busy      = busy_r;

endmodule
